// File: rtl/multi_rate_control_pkg.sv
// Shared types and constants for the multi-rate LFO controller.
// Divider states, derived widths and LFSR constants.
package multi_rate_control_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        STORE
    } div_state_t;

    function automatic int calc_nb(input int res_bits, input int trip_bits);
        return res_bits + trip_bits + 1;
    endfunction

    function automatic int calc_full_rate(input int res_bits);
        return 1 << res_bits;
    endfunction

    localparam int NB        = calc_nb(16, 11);
    localparam int FULL_RATE = calc_full_rate(16);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/multi_rate_control_rate_accumulator.sv
// Per-channel rate generator: sigma-delta accumulator, or an LFSR
// comparator when MULTI_RATE_CONTROL_DITHER_EN is defined.
module rate_accumulator
    import multi_rate_control_pkg::*;
#(
    parameter int RES_BITS = 16
`ifdef MULTI_RATE_CONTROL_DITHER_EN
    ,
    parameter logic [15:0] SEED = LFSR_SEED
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [RES_BITS:0] prob,
    output logic              incr_en
);

`ifdef MULTI_RATE_CONTROL_DITHER_EN

    logic [15:0] lfsr;
    logic        hit;

    assign hit = prob[RES_BITS] ||
                 ({1'b0, lfsr[RES_BITS-1:0]} < prob);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= SEED;
            incr_en <= 1'b0;
        end else begin
            incr_en <= tick & hit;
            if (tick) begin
                lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            end
        end
    end

`else

    logic [RES_BITS-1:0] acc;
    logic [RES_BITS:0]   sum;

    // Carry out of the accumulator is the pulse; the low bits persist.
    assign sum = {1'b0, acc} + prob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            incr_en <= 1'b0;
        end else begin
            incr_en <= tick & sum[RES_BITS];
            if (tick) begin
                acc <= sum[RES_BITS-1:0];
            end
        end
    end

`endif

endmodule

// File: rtl/multi_rate_control.sv
// LFO rate controller: shared serial divider feeding per-channel rate
// generators. MULTI_RATE_CONTROL_DITHER_EN selects LFSR dithered pulses.
module multi_rate_control
    import multi_rate_control_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int PERIOD_BITWIDTH = 18,
    parameter int RES_BITS        = 16,
    parameter int TRIP_BITS       = 11
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic                                 sample_tick_i,
    input  logic [CHANNELS*PERIOD_BITWIDTH-1:0]  period_i,
    output logic [CHANNELS-1:0]                  incr_en_o,
    output logic [CHANNELS*(RES_BITS+1)-1:0]     prob_o,
    output logic [CHANNELS-1:0]                  prob_valid_o
);

    localparam int PW         = PERIOD_BITWIDTH;
    localparam int DIV_CYCLES = calc_nb(RES_BITS, TRIP_BITS);
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1);
    localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [RES_BITS:0] FULL_PROB = {1'b1, {RES_BITS{1'b0}}};
    localparam logic [PW-1:0]     FAST_MAX  = PW'(2 ** TRIP_BITS);

    div_state_t state, state_nxt;

    logic [IDX_W-1:0]                 idx;
    logic [PW-1:0]                    per;
    logic [PW:0]                      rem;
    logic [RES_BITS:0]                quo;
    logic                             quo_ovf;
    logic [CNT_W-1:0]                 cnt;
    logic [CHANNELS-1:0][RES_BITS:0]  prob;
    logic [CHANNELS-1:0]              prob_valid;

    logic [PW-1:0]     per_sel;
    logic              fast;
    logic              div_last;
    logic              idx_last;
    logic [PW:0]       rem_shift;
    logic [PW:0]       rem_sub;
    logic              rem_ge;
    logic [RES_BITS:0] store_val;
    logic              st_load;
    logic              st_div;
    logic              st_store;

    assign per_sel  = period_i[idx*PW +: PW];
    assign fast     = (per_sel == '0) || (per_sel <= FAST_MAX);
    assign div_last = (cnt == CNT_W'(DIV_CYCLES - 1));
    assign idx_last = (idx == IDX_W'(CHANNELS - 1));

    // Numerator 2**(RES+TRIP) is a single 1 fed in on the first shift.
    assign rem_shift = {rem[PW-1:0], (cnt == '0)};
    assign rem_ge    = rem[PW] | (rem_shift >= {1'b0, per});
    assign rem_sub   = rem_shift - {1'b0, per};

    assign store_val = (quo_ovf || (quo > FULL_PROB)) ? FULL_PROB : quo;

    assign st_load  = (state == LOAD);
    assign st_div   = (state == DIV);
    assign st_store = (state == STORE);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    state_nxt = fast ? STORE : DIV;
            DIV:     state_nxt = div_last ? STORE : DIV;
            STORE:   state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            idx        <= '0;
            per        <= '0;
            rem        <= '0;
            quo        <= '0;
            quo_ovf    <= 1'b0;
            cnt        <= '0;
            prob       <= '0;
            prob_valid <= '0;
        end else begin
            unique case (1'b1)
                st_load: begin
                    per     <= per_sel;
                    rem     <= '0;
                    quo     <= '0;
                    quo_ovf <= fast;
                    cnt     <= '0;
                end
                st_div: begin
                    rem     <= rem_ge ? rem_sub : rem_shift;
                    quo     <= {quo[RES_BITS-1:0], rem_ge};
                    quo_ovf <= quo_ovf | quo[RES_BITS];
                    cnt     <= cnt + 1'b1;
                end
                st_store: begin
                    prob[idx]       <= store_val;
                    prob_valid[idx] <= 1'b1;
                    idx             <= idx_last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign prob_valid_o = prob_valid;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign prob_o[k*(RES_BITS+1) +: RES_BITS+1] = prob[k];

        rate_accumulator #(
            .RES_BITS(RES_BITS)
`ifdef MULTI_RATE_CONTROL_DITHER_EN
            ,
            .SEED(LFSR_SEED ^ 16'(k))
`endif
        ) u_acc (
            .clk    (clk_i),
            .rst    (arst_i),
            .tick   (sample_tick_i),
            .prob   (prob[k]),
            .incr_en(incr_en_o[k])
        );
    end

endmodule

// File: tb/tb_multi_rate_control.sv
// Directed bench for multi_rate_control: divider results, timing,
// reset behaviour, tick/store alignment and long-run pulse counts.
module tb_multi_rate_control;

    localparam int CH = 2;
    localparam int PW = 18;
    localparam int RB = 16;

`ifdef MULTI_RATE_CONTROL_DITHER_EN
    localparam logic [1:0] PAT_MASK = 2'b10;
`else
    localparam logic [1:0] PAT_MASK = 2'b11;
`endif

    logic                     clk_i = 1'b0;
    logic                     arst_i;
    logic                     sample_tick_i;
    logic [CH*PW-1:0]         period_i;
    logic [CH-1:0]            incr_en_o;
    logic [CH*(RB+1)-1:0]     prob_o;
    logic [CH-1:0]            prob_valid_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_i = ~clk_i;

    multi_rate_control #(
        .CHANNELS       (CH),
        .PERIOD_BITWIDTH(PW),
        .RES_BITS       (RB),
        .TRIP_BITS      (11)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .sample_tick_i(sample_tick_i),
        .period_i     (period_i),
        .incr_en_o    (incr_en_o),
        .prob_o       (prob_o),
        .prob_valid_o (prob_valid_o)
    );

    function automatic logic [RB:0] prob_of(input int k);
        return prob_o[k*(RB+1) +: RB+1];
    endfunction

    task automatic set_period(input int k, input int v);
        period_i[k*PW +: PW] = PW'(v);
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        arst_i = 1'b1;
        @(negedge clk_i);
        arst_i = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        arst_i        = 1'b1;
        sample_tick_i = 1'b0;
        period_i      = '0;
        wait_cycles(2);
        checks++;
        if (incr_en_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_incr_en: got %b expected 00", incr_en_o);
        end
        checks++;
        if (prob_o !== '0) begin
            errors++;
            $display("FAIL reset_prob: got %h expected 0", prob_o);
        end
        checks++;
        if (prob_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 00", prob_valid_o);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp;
        set_period(0, 4096);
        set_period(1, 2048);
        release_reset();
        wait_cycles(70);
        checks++;
        if (prob_valid_o !== 2'b11) begin
            errors++;
            $display("FAIL basic_valid: got %b expected 11", prob_valid_o);
        end
        checks++;
        if (prob_of(0) !== 17'd32768) begin
            errors++;
            $display("FAIL basic_prob0: got %0d expected 32768", prob_of(0));
        end
        checks++;
        if (prob_of(1) !== 17'd65536) begin
            errors++;
            $display("FAIL basic_prob1: got %0d expected 65536", prob_of(1));
        end
        for (int i = 0; i < 4; i++) begin
            sample_tick_i = 1'b1;
            step();
            exp = {1'b1, (i % 2 == 1)};
            checks++;
            if ((incr_en_o & PAT_MASK) !== (exp & PAT_MASK)) begin
                errors++;
                $display("FAIL basic_pulse%0d: got %b expected %b",
                         i, incr_en_o, exp);
            end
        end
        sample_tick_i = 1'b0;
        step();
        checks++;
        if (incr_en_o !== 2'b00) begin
            errors++;
            $display("FAIL basic_no_tick: got %b expected 00", incr_en_o);
        end
    endtask

    task automatic test_fast_path();
        set_period(0, 0);
        wait_cycles(70);
        checks++;
        if (prob_of(0) !== 17'd65536) begin
            errors++;
            $display("FAIL fast_zero: got %0d expected 65536", prob_of(0));
        end
        set_period(0, 6000);
        wait_cycles(70);
        checks++;
        if (prob_of(0) !== 17'd22369) begin
            errors++;
            $display("FAIL div_6000: got %0d expected 22369", prob_of(0));
        end
        set_period(0, 3);
        wait_cycles(70);
        checks++;
        if (prob_of(0) !== 17'd65536) begin
            errors++;
            $display("FAIL fast_three: got %0d expected 65536", prob_of(0));
        end
    endtask

    task automatic test_mid_div_change();
        set_period(0, 4096);
        set_period(1, 2048);
        release_reset();
        wait_cycles(10);
        set_period(0, 8192);
        wait_cycles(20);
        checks++;
        if (prob_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL middiv_valid30: got %b expected 00", prob_valid_o);
        end
        step();
        checks++;
        if (prob_of(0) !== 17'd32768 || prob_valid_o !== 2'b01) begin
            errors++;
            $display("FAIL middiv_store31: got %0d/%b expected 32768/01",
                     prob_of(0), prob_valid_o);
        end
        wait_cycles(31);
        checks++;
        if (prob_of(0) !== 17'd32768) begin
            errors++;
            $display("FAIL middiv_hold62: got %0d expected 32768", prob_of(0));
        end
        step();
        checks++;
        if (prob_of(0) !== 17'd16384) begin
            errors++;
            $display("FAIL middiv_store63: got %0d expected 16384", prob_of(0));
        end
    endtask

    task automatic test_store_tick();
        logic exp;
        set_period(0, 4096);
        set_period(1, 2048);
        release_reset();
        wait_cycles(10);
        set_period(0, 8192);
        wait_cycles(29);
        sample_tick_i = 1'b1;
        step();
        sample_tick_i = 1'b0;
        checks++;
        if (incr_en_o !== 2'b10) begin
            errors++;
            $display("FAIL storetick_pre: got %b expected 10", incr_en_o);
        end
        wait_cycles(22);
        sample_tick_i = 1'b1;
        step();
        checks++;
        if (incr_en_o !== 2'b11 || prob_of(0) !== 17'd16384) begin
            errors++;
            $display("FAIL storetick_old: got %b/%0d expected 11/16384",
                     incr_en_o, prob_of(0));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            exp = (i == 3);
            checks++;
            if (incr_en_o[0] !== exp) begin
                errors++;
                $display("FAIL storetick_new%0d: got %b expected %b",
                         i, incr_en_o[0], exp);
            end
        end
        sample_tick_i = 1'b0;
    endtask

    task automatic test_async_reset();
        set_period(0, 4096);
        set_period(1, 2048);
        release_reset();
        wait_cycles(40);
        sample_tick_i = 1'b1;
        wait_cycles(5);
        checks++;
        if (incr_en_o[1] !== 1'b1 || prob_valid_o !== 2'b11) begin
            errors++;
            $display("FAIL arst_pre: got %b/%b expected 1/11",
                     incr_en_o[1], prob_valid_o);
        end
        #2 arst_i = 1'b1;
        #1;
        checks++;
        if (incr_en_o !== 2'b00 || prob_o !== '0 ||
            prob_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL arst_async: got %b/%h/%b expected 00/0/00",
                     incr_en_o, prob_o, prob_valid_o);
        end
        sample_tick_i = 1'b0;
        set_period(0, 3);
        @(negedge clk_i);
        arst_i = 1'b0;
        cyc = 0;
        wait_cycles(2);
        checks++;
        if (prob_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL arst_restart2: got %b expected 00", prob_valid_o);
        end
        step();
        checks++;
        if (prob_valid_o !== 2'b01 || prob_of(0) !== 17'd65536) begin
            errors++;
            $display("FAIL arst_restart3: got %b/%0d expected 01/65536",
                     prob_valid_o, prob_of(0));
        end
        wait_cycles(2);
        checks++;
        if (prob_valid_o !== 2'b11) begin
            errors++;
            $display("FAIL arst_restart5: got %b expected 11", prob_valid_o);
        end
    endtask

    task automatic test_rate_count();
        int cnt0 = 0;
        int cnt1 = 0;
`ifdef MULTI_RATE_CONTROL_DITHER_EN
        set_period(0, 4096);
`else
        set_period(0, 6000);
`endif
        set_period(1, 2048);
        wait_cycles(70);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk_i);
            cnt0 += int'(incr_en_o[0]);
            cnt1 += int'(incr_en_o[1]);
            if (i == 65535) sample_tick_i = 1'b0;
        end
        checks++;
`ifdef MULTI_RATE_CONTROL_DITHER_EN
        if (cnt0 < 32768 - 655 || cnt0 > 32768 + 655) begin
            errors++;
            $display("FAIL rate_ch0: got %0d expected 32113..33423", cnt0);
        end
`else
        if (cnt0 != 22369) begin
            errors++;
            $display("FAIL rate_ch0: got %0d expected 22369", cnt0);
        end
`endif
        checks++;
        if (cnt1 != 65536) begin
            errors++;
            $display("FAIL rate_ch1: got %0d expected 65536", cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fast_path();
        test_mid_div_change();
`ifndef MULTI_RATE_CONTROL_DITHER_EN
        test_store_tick();
`endif
        test_async_reset();
        test_rate_count();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_rate_control.md
Name: multi_rate_control

Overview:
- Next-generation LFO rate controller for tremolo/modulation blocks.
- Converts CHANNELS independent requested LFO periods (in samples) into per-channel angle-increment-enable pulses that drive the sawtooth/CORDIC phase generators.
- One time-multiplexed serial divider is shared by all channels.
- Per-channel first-order sigma-delta accumulators give exact long-term rates, replacing random bitstreams; the random mode is kept as a compile option.

Parameters:
- CHANNELS, 2, number of independent LFO channels (1..8).
- PERIOD_BITWIDTH, 18, width of each requested period.
- RES_BITS, 16, probability resolution; full rate = 2**RES_BITS.
- TRIP_BITS, 11, log2 of samples per CORDIC round trip at full rate.

Ports:
- clk_i, input, 1, system clock.
- arst_i, input, 1, asynchronous active-high reset.
- sample_tick_i, input, 1, one-cycle audio sample strobe.
- period_i, input, CHANNELS*PERIOD_BITWIDTH, requested periods in samples; channel k occupies bits [k*PERIOD_BITWIDTH +: PERIOD_BITWIDTH].
- incr_en_o, output, CHANNELS, per-channel angle increment enable (one-cycle pulse).
- prob_o, output, CHANNELS*(RES_BITS+1), current per-channel increment probability (debug/visibility).
- prob_valid_o, output, CHANNELS, per-channel flag: first division result has been stored.

Behaviour:
- Reset (async, any time, including mid-division): all outputs, accumulators, probability registers, FSM and channel index are cleared. The FSM goes to IDLE; all prob_valid_o = 0.
- Target quotient: Q = 2**(RES_BITS+TRIP_BITS) / period, truncated. Store min(Q, 2**RES_BITS) in an RES_BITS+1 register.
- Fast path: period = 0 or period <= 2**TRIP_BITS stores 2**RES_BITS directly, without division.
- Divider FSM (round-robin over channels, free-running, never stalls):
  - IDLE: one cycle, then LOAD for channel idx.
  - LOAD: latch period_i[idx], clear remainder/quotient. Go to STORE if the fast path applies, else DIV.
  - DIV: restoring division, one quotient bit per cycle, NB = RES_BITS+TRIP_BITS+1 cycles.
  - STORE: write the clamped result to prob[idx]; set prob_valid[idx]. idx wraps at CHANNELS-1 to 0; go to LOAD.
- Period changes after LOAD are ignored until that channel's next turn.
- Update latency: at most CHANNELS*(NB+2)+1 cycles from a period change to the new probability (61 cycles at defaults).
- Rate generator, per channel, on each sample_tick_i:
  - sum = acc + prob (RES_BITS+1 bits).
  - incr_en_o[k] is registered as sum[RES_BITS], high for exactly the cycle after the tick.
  - acc <= sum[RES_BITS-1:0].
- No tick means no pulse and acc holds. A channel with prob_valid = 0 has prob = 0, so it never pulses.
- If STORE coincides with sample_tick_i, the tick uses the old prob and the new value applies from the next tick.
- prob = 2**RES_BITS means a pulse on every tick. Over 2**RES_BITS ticks at constant prob, the pulse count equals prob exactly (acc starts at 0).
- Arithmetic: all values are unsigned. The remainder register is PERIOD_BITWIDTH+1 bits wide. The numerator is implicit (a single 1 bit fed at the first shift), so no 28-bit constant register is needed.

Optional Feature:
- Macro: MULTI_RATE_CONTROL_DITHER_EN.
- Defined: each channel replaces the accumulator with a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1).
  - Seed is 16'hACE1 XOR channel index; it advances on each sample_tick_i.
  - Pulse when lfsr[RES_BITS-1:0] < prob, or always when prob = 2**RES_BITS.
  - Gives a Bernoulli, non-periodic rate.
- Undefined: deterministic sigma-delta behaviour as above.
- Divider, FSM and ports are identical in both builds.

Decomposition:
- Package multi_rate_control_pkg:
  - FSM state enum (IDLE, LOAD, DIV, STORE).
  - Localparams NB and FULL_RATE = 2**RES_BITS as functions of the parameters.
  - LFSR seed and taps constants.
- Sub-module rate_accumulator, one instance per channel: holds acc (or the LFSR under the macro) and produces incr_en. The divider FSM stays in the top.

Test Plan:
- Defaults; period0 = 4096, period1 = 2048 → after prob_valid = 2'b11, prob0 = 32768 and prob1 = 65536; ch0 pulses on every 2nd tick, ch1 on every tick.
- period0 = 6000 → prob0 = 22369; over 65536 ticks exactly 22369 pulses (macro undefined).
- period0 = 0 and period0 = 3 → prob0 = 65536 via the fast path; STORE is reached 2 cycles after LOAD.
- Change period0 from 4096 to 8192 mid-DIV → current STORE writes 32768; the next ch0 STORE writes 16384 within 61 cycles.
- Assert arst_i for 1 cycle during DIV while pulses are active → incr_en_o, prob_o and prob_valid_o drop to 0 immediately (async); the round-robin restarts at ch0.
- STORE cycle aligned with sample_tick_i → that tick's pulse uses the old prob; the new prob applies from the next tick. Under MULTI_RATE_CONTROL_DITHER_EN, prob = 32768 gives 50% ± 1% pulses over 65536 ticks.
